bcd_serial_adder: RTL and testbench

Digit-serial N-digit packed-BCD adder. It processes one BCD digit per clock, least-significant digit first, through a single 4-bit decimal-corrected digit adder and a carry register. It sits upstream of the single-digit BCD adder datapath and extends it to multi-digit operands with a start/done handshake. Results feed the display and accumulator logic downstream.

---
 rtl/bcd_serial_adder.sv | 125 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder. Operands are added one decimal digit per clock,
// least-significant digit first, through a single corrected digit adder.
module bcd_serial_adder #(
  parameter int NDIG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [4*NDIG-1:0] sum,
  output logic            cout,
  output logic            err
);
  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d, errp_q, errp_d;
  logic          cout_q, cout_d, err_q, err_d;

  logic          bad;
  logic [4:0]    raw;
  logic [3:0]    dig;
  logic          cy;

  always_comb begin
    // Flag any non-decimal nibble on either operand as presented at start.
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;

    // Invalid digits still follow the same rule; raw tops out at 31.
    raw = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);
    if (raw >= 5'd10) begin
      dig = 4'(raw - 5'd10);
      cy  = 1'b1;
    end else begin
      dig = raw[3:0];
      cy  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    errp_d  = errp_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          carry_d = cin;
          cnt_d   = '0;
          errp_d  = bad;
          state_d = ADD;
        end
      end
      ADD: begin
        // New digit enters at the MSD end so digit 0 lands at the LSB after NDIG shifts.
        res_d   = (res_q >> 4) | (W'(dig) << (W - 4));
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = cy;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          sum_d   = res_d;
          cout_d  = cy;
          err_d   = errp_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      errp_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      errp_q  <= errp_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and randomized checks of the digit-serial BCD adder against a
// whole-operand decimal reference model.
module tb_bcd_serial_adder;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0, exp_err = 1'b0;

  bcd_serial_adder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: add digit columns of the whole operands, carrying decimally.
  function automatic logic [W:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic c);
    logic [W-1:0] s;
    int cy, r;
    s  = '0;
    cy = int'(c);
    for (int i = 0; i < NDIG; i++) begin
      r = int'(av[4*i +: 4]) + int'(bv[4*i +: 4]) + cy;
      if (r >= 10) begin r = r - 10; cy = 1; end else cy = 0;
      s[4*i +: 4] = 4'(r);
    end
    return {cy[0], s};
  endfunction

  function automatic logic ref_err(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = 0; i < NDIG; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // One operation; with hold=1 start stays high through ADD and DONE and the
  // operand inputs are scrambled after capture.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input bit hold);
    logic [W:0] r;
    int npulse;
    r = ref_add(av, bv, c);
    npulse = 0;
    @(negedge clk);
    a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < NDIG; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold_sum"}, 32'(sum), 32'(exp_sum));
      if (done) npulse++;
      if (hold) begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
    end
    if (done) npulse++;
    exp_sum = r[W-1:0]; exp_cout = r[W]; exp_err = ref_err(av, bv);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) npulse++;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      @(negedge clk);
    end
    check({tag, "_npulse"}, 32'(npulse), 32'd1);
    check({tag, "_sum_kept"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("basic", 16'h1234, 16'h5678, 1'b0, 1'b0);
    do_op("ripple", 16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op("max", 16'h9999, 16'h9999, 1'b1, 1'b0);
    do_op("hold", 16'h0005, 16'h0004, 1'b0, 1'b1);
    do_op("bad", 16'h00A0, 16'h0001, 1'b0, 1'b0);
    do_op("clr_err", 16'h0001, 16'h0001, 1'b0, 1'b0);
    do_op("bad_hi", 16'hF0F0, 16'hFF0F, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      do_op("rand", rand_bcd(), rand_bcd(), 1'($urandom), 1'b0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < NDIG + 3; i++) begin
      check("arst_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    do_op("post_rst", 16'h4321, 16'h1234, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
